// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter: MEM load/store over IF fetch, byte-beat FSM,
// little-endian assembly, flush abort of fetches. Optional macro: IO_STALL_EN.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), flush (EX redirect)
//   if_req/if_addr -> if_done/if_data : instruction word fetch
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata -> mem_done/mem_rdata
//   ram_addr/ram_wr/ram_dout (registered), ram_din (one cycle after addr)
//   io_full : IO buffer full, honoured only when IO_STALL_EN is defined
//
// The RAM is assumed to share the rdy enable, so ram_din holds while rdy=0.
// The done pulses and the word being completed are driven in the cycle the
// last byte sits on ram_din; the word is also latched so the data output
// holds it until that port completes again.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              io_full
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_RD  = 2'd1;
  localparam logic [1:0] MEM_RD = 2'd2;
  localparam logic [1:0] MEM_WR = 2'd3;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [1:0]        size;
  logic [31:0]       wdata;
  logic [23:0]       rbuf;
  logic [31:0]       if_q;
  logic [31:0]       mem_q;

  logic [2:0]        nbytes;
  logic [2:0]        beat;
  logic [ADDR_W-1:0] beat_addr;
  logic              last;
  logic [31:0]       word;
  logic [7:0]        wbyte;
  logic              blk_grant;
  logic              blk_beat;

  always_comb begin
    unique case (size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // A stalled write retries the same beat; otherwise look one beat ahead.
  assign beat = (state == MEM_WR && !ram_wr) ? cnt : cnt + 3'd1;
  assign beat_addr = base + ADDR_W'(beat);
  assign last = (cnt == nbytes);

  always_comb begin
    unique case (beat[1:0])
      2'd0:    wbyte = wdata[7:0];
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      default: wbyte = wdata[31:24];
    endcase
  end

  always_comb begin
    unique case (size)
      2'd0:    word = {24'd0, ram_din};
      2'd1:    word = {16'd0, ram_din, rbuf[7:0]};
      default: word = {ram_din, rbuf};
    endcase
  end

`ifdef IO_STALL_EN
  assign blk_grant = io_full && (mem_addr[17:16] == 2'b11);
  assign blk_beat  = io_full && (beat_addr[17:16] == 2'b11);
`else
  logic unused_io;
  assign unused_io = io_full;
  assign blk_grant = 1'b0;
  assign blk_beat  = 1'b0;
`endif

  assign if_done   = rdy && state == IF_RD && last && !flush;
  assign mem_done  = rdy && state[1] && last;
  assign if_data   = if_done ? word : if_q;
  assign mem_rdata = mem_done ? word : mem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      base     <= '0;
      size     <= 2'd0;
      wdata    <= 32'd0;
      rbuf     <= 24'd0;
      if_q     <= 32'd0;
      mem_q    <= 32'd0;
      ram_addr <= '0;
      ram_wr   <= 1'b0;
      ram_dout <= 8'd0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          cnt  <= 3'd0;
          rbuf <= 24'd0;
          if (mem_req) begin
            state    <= mem_we ? MEM_WR : MEM_RD;
            base     <= mem_addr;
            size     <= mem_size;
            wdata    <= mem_wdata;
            ram_addr <= mem_addr;
            ram_dout <= mem_wdata[7:0];
            ram_wr   <= mem_we && !blk_grant;
          end else if (if_req && !flush) begin
            state    <= IF_RD;
            base     <= if_addr;
            size     <= 2'd2;
            ram_addr <= if_addr;
          end
        end
        IF_RD, MEM_RD: begin
          if (state == IF_RD && flush) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (last) begin
            state <= IDLE;
            cnt   <= 3'd0;
            if (state == IF_RD) if_q <= word;
            else mem_q <= word;
          end else begin
            cnt <= cnt + 3'd1;
            case (cnt)
              3'd1:    rbuf[7:0]   <= ram_din;
              3'd2:    rbuf[15:8]  <= ram_din;
              3'd3:    rbuf[23:16] <= ram_din;
              default: ;
            endcase
            if (beat < nbytes) ram_addr <= beat_addr;
          end
        end
        MEM_WR: begin
          if (last) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            if (ram_wr) cnt <= beat;
            if (beat < nbytes) begin
              ram_addr <= beat_addr;
              ram_dout <= wbyte;
              ram_wr   <= !blk_beat;
            end else begin
              ram_wr <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of load/store ops plus
// hand sequences for arbitration, flush, reset, freeze and IO stall.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        io_full;

  int pass_n = 0;
  int total_n = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din), .io_full(io_full)
  );

  // RAM model: synchronous read, output one cycle after the address,
  // enabled by the same global rdy.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
      ram_din <= ram[ram_addr[15:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  task automatic do_mem(input vec_t v, input int idx);
    int n;
    int dc;
    logic [31:0] sh;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    dc = 0;
    @(posedge clk); #1;
    mem_req = 1'b1;
    mem_we = v.we;
    mem_size = v.size;
    mem_addr = v.addr;
    mem_wdata = v.wdata;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (v.we && c <= n) begin
        sh = v.wdata >> (8 * (c - 1));
        chk($sformatf("v%0d_beat%0d", idx, c),
            {23'd0, ram_wr, ram_dout, ram_addr},
            {23'd0, 1'b1, sh[7:0], v.addr + 32'(c - 1)});
      end
      if (mem_done) begin
        dc = c;
        if (!v.we)
          chk($sformatf("v%0d_rdata", idx), 64'(mem_rdata), 64'(v.rdata));
      end
    end
    mem_req = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), 64'(dc), 64'(v.lat));
  endtask

  initial begin
    int md, id;
    logic [31:0] mrd, ird;

    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0;

    tbl[0]  = '{1'b1, 2'd2, 32'h40,       32'hDEADBEEF, 32'h0,        5};
    tbl[1]  = '{1'b0, 2'd2, 32'h40,       32'h0,        32'hDEADBEEF, 5};
    tbl[2]  = '{1'b0, 2'd1, 32'h42,       32'h0,        32'h0000DEAD, 3};
    tbl[3]  = '{1'b0, 2'd0, 32'h43,       32'h0,        32'h000000DE, 2};
    tbl[4]  = '{1'b1, 2'd2, 32'h80,       32'h11223344, 32'h0,        5};
    tbl[5]  = '{1'b1, 2'd1, 32'h80,       32'hFFFF5678, 32'h0,        3};
    tbl[6]  = '{1'b0, 2'd3, 32'h80,       32'h0,        32'h11225678, 5};
    tbl[7]  = '{1'b1, 2'd0, 32'h83,       32'h123456AA, 32'h0,        2};
    tbl[8]  = '{1'b0, 2'd2, 32'h80,       32'h0,        32'hAA225678, 5};
    tbl[9]  = '{1'b1, 2'd2, 32'hFFFFFFFE, 32'h01020304, 32'h0,        5};
    tbl[10] = '{1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h01020304, 5};
    tbl[11] = '{1'b0, 2'd1, 32'h0,        32'h0,        32'h00000102, 3};
    tbl[12] = '{1'b1, 2'd2, 32'h100,      32'h00000513, 32'h0,        5};
    tbl[13] = '{1'b1, 2'd2, 32'h200,      32'h00A00093, 32'h0,        5};
    tbl[14] = '{1'b1, 2'd0, 32'h2000,     32'h00000080, 32'h0,        2};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {ram_addr, if_data[15:0], mem_rdata[11:0], ram_dout, ram_wr,
         if_done, mem_done, 1'b0},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) do_mem(tbl[i], i);

    // fetch 0x100
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    id = 0; ird = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c <= 4)
        chk($sformatf("fetch_addr_c%0d", c), 64'(ram_addr),
            64'(32'h100 + 32'(c - 1)));
      if (c == 7) chk("fetch_data_hold", 64'(if_data), 64'h513);
      if (if_done) begin id = c; ird = if_data; if_req = 1'b0; end
    end
    chk("fetch_done_cycle", 64'(id), 64'd5);
    chk("fetch_data", 64'(ird), 64'h513);

    // MEM and IF request in the same cycle
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h100;
    md = 0; id = 0; mrd = 32'd0; ird = 32'd0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c == 3) chk("arb_bubble_addr", 64'(ram_addr), 64'h2000);
      if (c == 4) chk("arb_if_grant_addr", 64'(ram_addr), 64'h100);
      if (mem_done) begin md = c; mrd = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin id = c; ird = if_data; if_req = 1'b0; end
    end
    chk("arb_mem_done_cycle", 64'(md), 64'd2);
    chk("arb_mem_rdata", 64'(mrd), 64'h80);
    chk("arb_if_done_cycle", 64'(id), 64'd8);
    chk("arb_if_data", 64'(ird), 64'h513);

    // flush mid-fetch, then redirected fetch 0x200
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    id = 0; ird = 32'd0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 3) flush = 1'b1;
      if (c == 4) begin flush = 1'b0; if_addr = 32'h200; end
      @(negedge clk);
      if (c == 4) chk("flush_addr_hold", 64'(ram_addr), 64'h102);
      if (c == 5) chk("flush_regrant_addr", 64'(ram_addr), 64'h200);
      if (if_done && id == 0) begin id = c; ird = if_data; if_req = 1'b0; end
    end
    chk("flush_redirect_done_cycle", 64'(id), 64'd9);
    chk("flush_redirect_data", 64'(ird), 64'h00A00093);

    // flush in the cycle of the final byte suppresses if_done
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    id = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 5) flush = 1'b1;
      if (c == 6) begin flush = 1'b0; if_req = 1'b0; end
      @(negedge clk);
      if (if_done) id = c;
    end
    chk("flush_last_no_done", 64'(id), 64'd0);
    chk("flush_last_data_hold", 64'(if_data), 64'h00A00093);

    // reset in cycle 2 of a halfword store
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1;
    mem_addr = 32'h300; mem_wdata = 32'h0000BEEF;
    md = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b0;
      if (c == 3) begin rst = 1'b1; mem_req = 1'b0; end
      @(negedge clk);
      if (c == 3)
        chk("rst_mid_state",
            {ram_addr, mem_rdata[15:0], if_data[15:0]}, 64'd0);
      if (c == 3)
        chk("rst_mid_strobes", {61'd0, ram_wr, mem_done, if_done}, 64'd0);
      if (mem_done) md = c;
    end
    chk("rst_mid_no_done", 64'(md), 64'd0);

    // rdy low for three cycles during a word load
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h40;
    md = 0; mrd = 32'd0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
      @(negedge clk);
      if (c == 3 || c == 4)
        chk($sformatf("freeze_addr_c%0d", c), {ram_addr, 31'd0, mem_done},
            {32'h41, 32'd0});
      if (mem_done && md == 0) begin md = c; mrd = mem_rdata; mem_req = 1'b0; end
    end
    chk("freeze_done_cycle", 64'(md), 64'd8);
    chk("freeze_rdata", 64'(mrd), 64'hDEADBEEF);

    // byte store to the IO window with io_full asserted
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0;
    mem_addr = 32'h30000; mem_wdata = 32'h00000041; io_full = 1'b1;
    md = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
`ifdef IO_STALL_EN
      if (c == 4) io_full = 1'b0;
      @(negedge clk);
      if (c <= 4) chk($sformatf("io_stall_c%0d", c), 64'(ram_wr), 64'd0);
      if (c == 5)
        chk("io_issue", {23'd0, ram_wr, ram_dout, ram_addr},
            {23'd0, 1'b1, 8'h41, 32'h30000});
`else
      @(negedge clk);
      if (c == 1)
        chk("io_ignored_issue", {23'd0, ram_wr, ram_dout, ram_addr},
            {23'd0, 1'b1, 8'h41, 32'h30000});
`endif
      if (mem_done && md == 0) begin md = c; mem_req = 1'b0; end
    end
    io_full = 1'b0;
`ifdef IO_STALL_EN
    chk("io_done_cycle", 64'(md), 64'd6);
`else
    chk("io_done_cycle", 64'(md), 64'd2);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
